rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/eth_rx_pkg.sv | 21 ++
 rtl/eth_sat_cnt.sv | 17 +
 rtl/rx_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RGMII-style receive frame controller.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // One decoded capture cycle: full byte plus data-valid and error strobes.
  typedef struct packed {
    logic [7:0] data;
    logic       dv;
    logic       er;
  } rx_cap_t;

endpackage

// File: rtl/eth_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module eth_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count increments, clear wins, stop at the top value.
  always_ff @(posedge clk) begin
    if (clr)                   cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: strips preamble/SFD from DDR-captured nibbles,
// delivers frame bytes through a one-byte hold stage, flags runt/oversize/
// line-error frames at end-of-frame and keeps good/errored frame counts.
module rx_frame_ctrl
  import eth_rx_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic             inclock,
  input  logic             aclr,
  input  logic [6:0]       data_h,
  input  logic [6:0]       data_l,
  input  logic             rx_en,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  output logic             byte_sof,
  output logic             byte_eof,
  output logic             byte_err,
  output logic [10:0]      frame_len,
  output logic             crs,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);

  rx_cap_t   cap;
  rx_state_e state, state_nxt;

  // Hold stage and per-frame bookkeeping.
  logic [7:0]  hold_byte, hold_byte_nxt;
  logic        hold_vld, hold_vld_nxt;
  logic [10:0] len, len_nxt;          // bytes accepted into the frame so far
  logic        err_acc, err_acc_nxt;  // any line error seen during DATA
  logic        sof_pend, sof_pend_nxt;
  logic        seen_pre, seen_pre_nxt;

  // Per-cycle emit decisions, registered onto the outputs.
  logic emit, emit_sof, emit_eof, emit_err;

  logic unused_bits;
  assign unused_bits = ^{data_h[6], data_l[6], data_l[5]};

  // Capture words arrive straight from the DDR buffer; decode combinationally.
  assign cap.data = {data_l[3:0], data_h[3:0]};
  assign cap.dv   = data_h[4];
  assign cap.er   = data_h[4] ^ data_l[4];

  // State and hold-stage registers; reset parks in DROP so a frame already
  // on the wire is never picked up mid-way.
  always_ff @(posedge inclock) begin
    if (aclr) begin
      state     <= ST_DROP;
      hold_byte <= '0;
      hold_vld  <= 1'b0;
      len       <= '0;
      err_acc   <= 1'b0;
      sof_pend  <= 1'b0;
      seen_pre  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_byte <= hold_byte_nxt;
      hold_vld  <= hold_vld_nxt;
      len       <= len_nxt;
      err_acc   <= err_acc_nxt;
      sof_pend  <= sof_pend_nxt;
      seen_pre  <= seen_pre_nxt;
    end
  end

  // Next-state logic and byte-emit decisions.
  always_comb begin
    state_nxt     = state;
    hold_byte_nxt = hold_byte;
    hold_vld_nxt  = hold_vld;
    len_nxt       = len;
    err_acc_nxt   = err_acc;
    sof_pend_nxt  = sof_pend;
    seen_pre_nxt  = seen_pre;
    emit          = 1'b0;
    emit_sof      = 1'b0;
    emit_eof      = 1'b0;
    emit_err      = 1'b0;
    unique case (state)
      ST_DROP: begin
        if (!cap.dv) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (cap.dv) begin
          if (rx_en) begin
            state_nxt    = ST_PREAMBLE;
            seen_pre_nxt = (cap.data == PREAMBLE_BYTE);
          end else begin
            state_nxt = ST_DROP;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!cap.dv)                             state_nxt = ST_IDLE;
        else if (cap.er)                         state_nxt = ST_DROP;
        else if (cap.data == PREAMBLE_BYTE)      seen_pre_nxt = 1'b1;
        else if (cap.data == SFD_BYTE && seen_pre) begin
          state_nxt    = ST_DATA;
          hold_vld_nxt = 1'b0;
          len_nxt      = '0;
          err_acc_nxt  = 1'b0;
          sof_pend_nxt = 1'b1;
        end else begin
          state_nxt = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!cap.dv) begin
          // End of carrier: flush the held byte as the last one.
          state_nxt    = ST_IDLE;
          hold_vld_nxt = 1'b0;
          if (hold_vld) begin
            emit     = 1'b1;
            emit_sof = sof_pend;
            emit_eof = 1'b1;
            emit_err = err_acc | (len < MIN_L);
          end
        end else if (hold_vld && len == MAX_L) begin
          // A byte beyond the limit: cut the frame at the held byte.
          state_nxt    = ST_DROP;
          hold_vld_nxt = 1'b0;
          emit         = 1'b1;
          emit_sof     = sof_pend;
          emit_eof     = 1'b1;
          emit_err     = 1'b1;
        end else begin
          if (hold_vld) begin
            emit         = 1'b1;
            emit_sof     = sof_pend;
            sof_pend_nxt = 1'b0;
          end
          hold_byte_nxt = cap.data;
          hold_vld_nxt  = 1'b1;
          len_nxt       = len + 11'd1;
          err_acc_nxt   = err_acc | cap.er;
        end
      end
      default: state_nxt = ST_DROP;
    endcase
  end

  // Registered byte interface; strobes are low whenever nothing is emitted.
  always_ff @(posedge inclock) begin
    if (aclr) begin
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_sof   <= 1'b0;
      byte_eof   <= 1'b0;
      byte_err   <= 1'b0;
      frame_len  <= '0;
      crs        <= 1'b0;
    end else begin
      if (emit) byte_data <= hold_byte;
      byte_valid <= emit;
      byte_sof   <= emit_sof;
      byte_eof   <= emit_eof;
      byte_err   <= emit_err;
      frame_len  <= emit_eof ? len : 11'd0;
      crs        <= data_h[5];
    end
  end

  eth_sat_cnt #(.W(CNT_W)) u_good_cnt (
    .clk (inclock),
    .clr (aclr),
    .inc (emit_eof & ~emit_err),
    .cnt (frame_cnt)
  );

  eth_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk (inclock),
    .clr (aclr),
    .inc (emit_eof & emit_err),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl.
module tb_rx_frame_ctrl;

  logic        inclock = 1'b0;
  logic        aclr;
  logic [6:0]  data_h, data_l;
  logic        rx_en;
  logic [7:0]  byte_data;
  logic        byte_valid, byte_sof, byte_eof, byte_err, crs;
  logic [10:0] frame_len;
  logic [15:0] frame_cnt, err_cnt;

  int checks = 0;
  int failures = 0;

  // Output monitor state (cleared per scenario).
  int          nvalid, sof_cnt, eof_cnt, bad_ctrl, post_eof;
  logic [7:0]  sof_data, eof_data;
  logic [10:0] eof_len;
  logic        eof_err;
  logic [7:0]  got [0:2047];

  int exp_good = 0;
  int exp_bad  = 0;

  rx_frame_ctrl dut (
    .inclock(inclock), .aclr(aclr), .data_h(data_h), .data_l(data_l), .rx_en(rx_en),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_sof(byte_sof),
    .byte_eof(byte_eof), .byte_err(byte_err), .frame_len(frame_len), .crs(crs),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 inclock = ~inclock;

  always @(negedge inclock) begin
    if (byte_valid) begin
      if (nvalid < 2048) got[nvalid] = byte_data;
      if (eof_cnt > 0) post_eof++;
      nvalid++;
      if (byte_sof) begin sof_cnt++; sof_data = byte_data; end
      if (byte_eof) begin eof_cnt++; eof_data = byte_data; eof_len = frame_len; eof_err = byte_err; end
    end else if (byte_sof || byte_eof || byte_err) begin
      bad_ctrl++;
    end
  end

  task automatic mon_clear();
    nvalid = 0; sof_cnt = 0; eof_cnt = 0; bad_ctrl = 0; post_eof = 0;
    sof_data = '0; eof_data = '0; eof_len = '0; eof_err = 1'b0;
  endtask

  // Apply one capture cycle; returns 2 time units after the edge that sampled it.
  task automatic put(input logic [6:0] h, input logic [6:0] l);
    data_h = h; data_l = l;
    @(posedge inclock); #2;
  endtask

  task automatic put_byte(input logic [7:0] b, input bit er);
    put({1'b0, 1'b1, 1'b1, b[3:0]}, {1'b0, 1'b1, ~er, b[7:4]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(7'h00, 7'h00);
  endtask

  task automatic preamble();
    for (int i = 0; i < 7; i++) put_byte(8'h55, 1'b0);
    put_byte(8'hD5, 1'b0);
  endtask

  // Frame of n bytes valued i[7:0]; er on byte er_idx; rx_en dropped at en_off.
  task automatic send_frame(input int n, input int er_idx, input int en_off);
    preamble();
    for (int i = 0; i < n; i++) begin
      if (i == en_off) rx_en = 1'b0;
      put_byte(8'(i), i == er_idx);
    end
    idle(3);
  endtask

  function automatic int data_errs();
    int bad = 0;
    for (int i = 0; i < nvalid && i < 2048; i++) if (got[i] !== 8'(i)) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    aclr = 1'b1; rx_en = 1'b1; data_h = 7'h7F; data_l = 7'h7F;
    @(posedge inclock); #2;
    data_h = 7'h00; data_l = 7'h00;
    @(posedge inclock); #2;
    checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", byte_valid); end
    checks++; if ({byte_sof, byte_eof, byte_err} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {byte_sof, byte_eof, byte_err}); end
    checks++; if (frame_len !== 11'd0 || byte_data !== 8'd0 || crs !== 1'b0) begin failures++; $display("FAIL rst_data len=%0d data=%h crs=%b exp=0", frame_len, byte_data, crs); end
    checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", frame_cnt, err_cnt); end
    aclr = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame();
    mon_clear();
    send_frame(64, -1, -1);
    exp_good++;
    checks++; if (nvalid !== 64) begin failures++; $display("FAIL good_nvalid got=%0d exp=64", nvalid); end
    checks++; if (sof_cnt !== 1 || sof_data !== 8'h00) begin failures++; $display("FAIL good_sof cnt=%0d data=%h exp=1/00", sof_cnt, sof_data); end
    checks++; if (eof_cnt !== 1 || eof_data !== 8'h3F) begin failures++; $display("FAIL good_eof cnt=%0d data=%h exp=1/3f", eof_cnt, eof_data); end
    checks++; if (eof_len !== 11'd64 || eof_err !== 1'b0) begin failures++; $display("FAIL good_len len=%0d err=%b exp=64/0", eof_len, eof_err); end
    checks++; if (data_errs() !== 0) begin failures++; $display("FAIL good_data errs=%0d exp=0", data_errs()); end
    checks++; if (bad_ctrl !== 0) begin failures++; $display("FAIL good_ctrl stray=%0d exp=0", bad_ctrl); end
    checks++; if (frame_cnt !== 16'(exp_good) || err_cnt !== 16'(exp_bad)) begin failures++; $display("FAIL good_cnt got=%0d/%0d exp=%0d/%0d", frame_cnt, err_cnt, exp_good, exp_bad); end
  endtask

  task automatic test_er_frame();
    mon_clear();
    send_frame(64, 10, -1);
    exp_bad++;
    checks++; if (eof_cnt !== 1 || eof_err !== 1'b1 || eof_len !== 11'd64) begin failures++; $display("FAIL er_eof cnt=%0d err=%b len=%0d exp=1/1/64", eof_cnt, eof_err, eof_len); end
    checks++; if (frame_cnt !== 16'(exp_good) || err_cnt !== 16'(exp_bad)) begin failures++; $display("FAIL er_cnt got=%0d/%0d exp=%0d/%0d", frame_cnt, err_cnt, exp_good, exp_bad); end
  endtask

  task automatic test_runt();
    mon_clear();
    send_frame(20, -1, -1);
    exp_bad++;
    checks++; if (eof_cnt !== 1 || eof_err !== 1'b1 || eof_len !== 11'd20 || eof_data !== 8'h13) begin failures++; $display("FAIL runt_eof cnt=%0d err=%b len=%0d data=%h exp=1/1/20/13", eof_cnt, eof_err, eof_len, eof_data); end
    checks++; if (nvalid !== 20 || err_cnt !== 16'(exp_bad)) begin failures++; $display("FAIL runt_cnt nvalid=%0d err_cnt=%0d exp=20/%0d", nvalid, err_cnt, exp_bad); end
  endtask

  // Two-byte frame stepped cycle by cycle to pin down latency and flag timing.
  task automatic test_latency();
    preamble();
    put_byte(8'hA5, 1'b0);
    checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL lat_early valid=%b exp=0", byte_valid); end
    checks++; if (crs !== 1'b1) begin failures++; $display("FAIL lat_crs got=%b exp=1", crs); end
    put_byte(8'h3C, 1'b0);
    checks++; if ({byte_valid, byte_sof, byte_eof} !== 3'b110 || byte_data !== 8'hA5) begin failures++; $display("FAIL lat_first vse=%b data=%h exp=110/a5", {byte_valid, byte_sof, byte_eof}, byte_data); end
    put(7'h00, 7'h00);
    exp_bad++;
    checks++; if ({byte_valid, byte_sof, byte_eof, byte_err} !== 4'b1011 || byte_data !== 8'h3C || frame_len !== 11'd2) begin failures++; $display("FAIL lat_last vsee=%b data=%h len=%0d exp=1011/3c/2", {byte_valid, byte_sof, byte_eof, byte_err}, byte_data, frame_len); end
    checks++; if (err_cnt !== 16'(exp_bad)) begin failures++; $display("FAIL lat_errcnt got=%0d exp=%0d", err_cnt, exp_bad); end
    put(7'h00, 7'h00);
    checks++; if ({byte_valid, byte_eof, frame_len} !== 13'd0) begin failures++; $display("FAIL lat_after valid=%b eof=%b len=%0d exp=0", byte_valid, byte_eof, frame_len); end
    idle(2);
  endtask

  task automatic test_one_byte();
    mon_clear();
    send_frame(1, -1, -1);
    exp_bad++;
    checks++; if (nvalid !== 1 || sof_cnt !== 1 || eof_cnt !== 1 || eof_len !== 11'd1 || eof_err !== 1'b1) begin failures++; $display("FAIL one_byte n=%0d sof=%0d eof=%0d len=%0d err=%b exp=1/1/1/1/1", nvalid, sof_cnt, eof_cnt, eof_len, eof_err); end
  endtask

  task automatic test_oversize();
    mon_clear();
    send_frame(1600, -1, -1);
    exp_bad++;
    checks++; if (nvalid !== 1518) begin failures++; $display("FAIL over_nvalid got=%0d exp=1518", nvalid); end
    checks++; if (eof_cnt !== 1 || eof_err !== 1'b1 || eof_len !== 11'd1518 || eof_data !== 8'hED) begin failures++; $display("FAIL over_eof cnt=%0d err=%b len=%0d data=%h exp=1/1/1518/ed", eof_cnt, eof_err, eof_len, eof_data); end
    checks++; if (post_eof !== 0 || data_errs() !== 0) begin failures++; $display("FAIL over_tail post=%0d data_errs=%0d exp=0/0", post_eof, data_errs()); end
    checks++; if (err_cnt !== 16'(exp_bad) || frame_cnt !== 16'(exp_good)) begin failures++; $display("FAIL over_cnt got=%0d/%0d exp=%0d/%0d", frame_cnt, err_cnt, exp_good, exp_bad); end
    mon_clear();
    send_frame(64, -1, -1);
    exp_good++;
    checks++; if (nvalid !== 64 || eof_err !== 1'b0 || frame_cnt !== 16'(exp_good)) begin failures++; $display("FAIL over_next n=%0d err=%b fcnt=%0d exp=64/0/%0d", nvalid, eof_err, frame_cnt, exp_good); end
  endtask

  task automatic test_bad_preamble();
    mon_clear();
    put_byte(8'h55, 1'b0); put_byte(8'h55, 1'b0); put_byte(8'h5D, 1'b0);
    put_byte(8'hD5, 1'b0); put_byte(8'h00, 1'b0); put_byte(8'h01, 1'b0);
    idle(3);
    checks++; if (nvalid !== 0 || bad_ctrl !== 0) begin failures++; $display("FAIL badpre_out n=%0d stray=%0d exp=0/0", nvalid, bad_ctrl); end
    send_frame(64, -1, -1);
    exp_good++;
    checks++; if (nvalid !== 64 || eof_cnt !== 1 || eof_err !== 1'b0 || frame_cnt !== 16'(exp_good)) begin failures++; $display("FAIL badpre_next n=%0d eof=%0d err=%b fcnt=%0d exp=64/1/0/%0d", nvalid, eof_cnt, eof_err, frame_cnt, exp_good); end
  endtask

  task automatic test_reset_midframe();
    preamble();
    for (int i = 0; i < 30; i++) put_byte(8'(i), 1'b0);
    aclr = 1'b1;
    put_byte(8'd30, 1'b0);
    aclr = 1'b0;
    exp_good = 0; exp_bad = 0;
    mon_clear();
    checks++; if (byte_valid !== 1'b0 || byte_eof !== 1'b0 || frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin failures++; $display("FAIL midrst_out valid=%b eof=%b cnt=%0d/%0d exp=0", byte_valid, byte_eof, frame_cnt, err_cnt); end
    for (int i = 31; i < 64; i++) put_byte(8'(i), 1'b0);
    idle(3);
    checks++; if (nvalid !== 0 || eof_cnt !== 0 || bad_ctrl !== 0) begin failures++; $display("FAIL midrst_tail n=%0d eof=%0d stray=%0d exp=0/0/0", nvalid, eof_cnt, bad_ctrl); end
    send_frame(64, -1, -1);
    exp_good++;
    checks++; if (nvalid !== 64 || eof_len !== 11'd64 || frame_cnt !== 16'(exp_good) || err_cnt !== 16'd0) begin failures++; $display("FAIL midrst_next n=%0d len=%0d cnt=%0d/%0d exp=64/64/%0d/0", nvalid, eof_len, frame_cnt, err_cnt, exp_good); end
  endtask

  task automatic test_rx_en();
    mon_clear();
    rx_en = 1'b1;
    send_frame(64, -1, 5);
    exp_good++;
    checks++; if (nvalid !== 64 || eof_err !== 1'b0 || frame_cnt !== 16'(exp_good)) begin failures++; $display("FAIL en_mid n=%0d err=%b fcnt=%0d exp=64/0/%0d", nvalid, eof_err, frame_cnt, exp_good); end
    mon_clear();
    send_frame(64, -1, -1);
    checks++; if (nvalid !== 0 || frame_cnt !== 16'(exp_good) || err_cnt !== 16'(exp_bad)) begin failures++; $display("FAIL en_off n=%0d cnt=%0d/%0d exp=0/%0d/%0d", nvalid, frame_cnt, err_cnt, exp_good, exp_bad); end
    rx_en = 1'b1;
  endtask

  initial begin
    mon_clear();
    test_reset();
    test_good_frame();
    test_er_frame();
    test_runt();
    test_latency();
    test_one_byte();
    test_oversize();
    test_bad_preamble();
    test_reset_midframe();
    test_rx_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
